// File: rtl/valid_dirty_array.sv
// Per-set/per-way valid+dirty status with invalidate-all and dirty-line flush sequencers.
// Latency: status of set Address one falling edge later; writes visible on the next edge's read.
// Backpressure: a flush offer is held on WbValid/WbIndex/WbWay until WbReady; the sweep stalls meanwhile.
module valid_dirty_array #(
    parameter int INDEX_WIDTH = 8,
    parameter int NUM_WAYS    = 2,
    localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [INDEX_WIDTH-1:0] Address,
    input  logic [WAY_W-1:0]       Way,
    input  logic                   Write,
    input  logic                   ValidIn,
    input  logic                   DirtyIn,
    output logic [NUM_WAYS-1:0]    ValidOut,
    output logic [NUM_WAYS-1:0]    DirtyOut,
    input  logic                   InvalidateAll,
    input  logic                   Flush,
    output logic                   Busy,
    output logic                   Done,
    output logic                   WbValid,
    input  logic                   WbReady,
    output logic [INDEX_WIDTH-1:0] WbIndex,
    output logic [WAY_W-1:0]       WbWay
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] IDX_LAST = {INDEX_WIDTH{1'b1}};
    localparam logic [WAY_W-1:0]       WAY_LAST = WAY_W'(NUM_WAYS - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_WB, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] ptr_idx_q, ptr_idx_d, adv_idx;
    logic [WAY_W-1:0]       ptr_way_q, ptr_way_d, adv_way;
    logic [NUM_WAYS-1:0]    valid_q [DEPTH];
    logic [NUM_WAYS-1:0]    dirty_q [DEPTH];

    logic start, clear_row, wb_ack, scan_hit, last_entry, wr_en, rd_block;

    assign Busy    = (state_q == S_CLEAR) || (state_q == S_SCAN) || (state_q == S_WB);
    assign Done    = (state_q == S_DONE);
    assign WbValid = (state_q == S_WB);
    assign WbIndex = WbValid ? ptr_idx_q : '0;
    assign WbWay   = WbValid ? ptr_way_q : '0;

    assign last_entry = (ptr_idx_q == IDX_LAST) && (ptr_way_q == WAY_LAST);
    assign adv_way    = (ptr_way_q == WAY_LAST) ? '0 : ptr_way_q + WAY_W'(1);
    assign adv_idx    = (ptr_way_q == WAY_LAST) ? ptr_idx_q + INDEX_WIDTH'(1) : ptr_idx_q;

    // Writes are allowed in IDLE (unless a command is taken on the same edge) and in DONE.
    assign wr_en    = Write && (((state_q == S_IDLE) && !start) || (state_q == S_DONE));
    // Blank the read on the command edge too, so the cache sees misses for the whole sweep.
    assign rd_block = Busy || start;

    always_comb begin
        scan_hit = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (ptr_way_q == WAY_W'(w)) begin
                scan_hit = valid_q[ptr_idx_q][w] & dirty_q[ptr_idx_q][w];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_idx_d = ptr_idx_q;
        ptr_way_d = ptr_way_q;
        start     = 1'b0;
        clear_row = 1'b0;
        wb_ack    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (InvalidateAll || Flush) begin
                    start     = 1'b1;
                    state_d   = InvalidateAll ? S_CLEAR : S_SCAN;
                    ptr_idx_d = '0;
                    ptr_way_d = '0;
                end
            end
            S_CLEAR: begin
                clear_row = 1'b1;
                ptr_idx_d = ptr_idx_q + INDEX_WIDTH'(1);
                if (ptr_idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_SCAN: begin
                if (scan_hit) begin
                    state_d = S_WB;
                end else begin
                    ptr_idx_d = adv_idx;
                    ptr_way_d = adv_way;
                    if (last_entry) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WB: begin
                if (WbReady) begin
                    wb_ack    = 1'b1;
                    ptr_idx_d = adv_idx;
                    ptr_way_d = adv_way;
                    state_d   = last_entry ? S_DONE : S_SCAN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(negedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            ptr_idx_q <= '0;
            ptr_way_q <= '0;
            ValidOut  <= '0;
            DirtyOut  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_idx_q <= ptr_idx_d;
            ptr_way_q <= ptr_way_d;
            ValidOut  <= rd_block ? '0 : valid_q[Address];
            DirtyOut  <= rd_block ? '0 : dirty_q[Address];
        end
    end

    always_ff @(negedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= '0;
                dirty_q[i] <= '0;
            end
        end else begin
            if (clear_row) begin
                valid_q[ptr_idx_q] <= '0;
                dirty_q[ptr_idx_q] <= '0;
            end
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (wb_ack && (ptr_way_q == WAY_W'(w))) begin
                    dirty_q[ptr_idx_q][w] <= 1'b0;
                end
                // Dirty is only ever stored alongside a valid line.
                if (wr_en && (Way == WAY_W'(w))) begin
                    valid_q[Address][w] <= ValidIn;
                    dirty_q[Address][w] <= ValidIn & DirtyIn;
                end
            end
        end
    end

endmodule

// File: tb/tb_valid_dirty_array.sv
// Bench for valid_dirty_array: random reads/writes and sweeps checked against an array model.
module tb_valid_dirty_array;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [2:0] Address;
    logic [0:0] Way;
    logic       Write, ValidIn, DirtyIn;
    logic [1:0] ValidOut, DirtyOut;
    logic       InvalidateAll, Flush, Busy, Done, WbValid, WbReady;
    logic [2:0] WbIndex;
    logic [0:0] WbWay;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] mv [8];
    logic [1:0] md [8];

    valid_dirty_array #(.INDEX_WIDTH(3), .NUM_WAYS(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Address(Address), .Way(Way), .Write(Write),
        .ValidIn(ValidIn), .DirtyIn(DirtyIn), .ValidOut(ValidOut), .DirtyOut(DirtyOut),
        .InvalidateAll(InvalidateAll), .Flush(Flush), .Busy(Busy), .Done(Done),
        .WbValid(WbValid), .WbReady(WbReady), .WbIndex(WbIndex), .WbWay(WbWay)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 2'b00;
            md[i] = 2'b00;
        end
    endfunction

    // Apply inputs, let the DUT take one falling edge, return at the following rising edge.
    task automatic drive_edge(input int a, input int wr, input int w, input int v, input int d,
                              input int inv, input int fl, input int rdy);
        Address       = 3'(a);
        Write         = 1'(wr);
        Way           = 1'(w);
        ValidIn       = 1'(v);
        DirtyIn       = 1'(d);
        InvalidateAll = 1'(inv);
        Flush         = 1'(fl);
        WbReady       = 1'(rdy);
        @(negedge Clk);
        @(posedge Clk);
    endtask

    task automatic idle_edge(input int a, input int wr, input int w, input int v, input int d);
        logic [1:0] ev, ed;
        ev = mv[a];
        ed = md[a];
        drive_edge(a, wr, w, v, d, 0, 0, $urandom_range(0, 1));
        if (wr != 0) begin
            mv[a][w] = 1'(v);
            md[a][w] = 1'(v & d);
        end
        check("rd_valid", 32'(ValidOut), 32'(ev));
        check("rd_dirty", 32'(DirtyOut), 32'(ed));
        check("idle_flags", 32'({Busy, Done, WbValid}), 32'(0));
    endtask

    task automatic read_sweep();
        for (int a = 0; a < 8; a++) idle_edge(a, 0, 0, 0, 0);
    endtask

    task automatic run_invalidate();
        int n_busy;
        n_busy = 0;
        drive_edge($urandom_range(0, 7), 1, $urandom_range(0, 1), 1, 1, 1, $urandom_range(0, 1), 0);
        while (Busy && n_busy < 100) begin
            n_busy++;
            check("inv_rd", 32'({ValidOut, DirtyOut}), 32'(0));
            drive_edge($urandom_range(0, 7), 1, $urandom_range(0, 1), 1, 1, 0, 0, 0);
        end
        check("inv_done", 32'(Done), 32'(1));
        check("inv_len", 32'(n_busy), 32'(8));
        model_clear();
    endtask

    task automatic run_flush(input int rand_rdy, input int first_stall);
        logic [3:0] q[$];
        logic [3:0] held;
        int n_busy, stalls, k, cur_stall, rdy;
        bit first, pend;
        for (int i = 0; i < 8; i++)
            for (int w = 0; w < 2; w++)
                if (mv[i][w] && md[i][w]) q.push_back({3'(i), 1'(w)});
        k = q.size();
        n_busy = 0; stalls = 0; cur_stall = 0; first = 1; pend = 0; held = '0;
        drive_edge($urandom_range(0, 7), 1, $urandom_range(0, 1), 1, 1, 0, 1, 0);
        while (Busy && n_busy < 200) begin
            n_busy++;
            check("flush_rd", 32'({ValidOut, DirtyOut}), 32'(0));
            if (pend) check("wb_hold", 32'({WbValid, WbIndex, WbWay}), 32'({1'b1, held}));
            rdy = $urandom_range(0, 1);
            pend = 0;
            if (WbValid) begin
                if (q.size() > 0) check("wb_entry", 32'({WbIndex, WbWay}), 32'(q[0]));
                else check("wb_extra", 32'(WbValid), 32'(0));
                if (first) rdy = (cur_stall >= first_stall) ? 1 : 0;
                else if (rand_rdy == 0) rdy = 1;
                if (rdy != 0) begin
                    if (q.size() > 0) void'(q.pop_front());
                    md[WbIndex][WbWay] = 1'b0;
                    first = 0;
                end else begin
                    stalls++;
                    cur_stall++;
                    pend = 1;
                    held = {WbIndex, WbWay};
                end
            end
            drive_edge($urandom_range(0, 7), 1, $urandom_range(0, 1), 1, 1,
                       0, $urandom_range(0, 1), rdy);
        end
        check("flush_done", 32'(Done), 32'(1));
        check("flush_len", 32'(n_busy), 32'(16 + k + stalls));
        check("flush_left", 32'(q.size()), 32'(0));
    endtask

    initial begin
        int n;
        model_clear();
        Reset_n = 1'b0;
        Address = '0; Way = '0; Write = 0; ValidIn = 0; DirtyIn = 0;
        InvalidateAll = 0; Flush = 0; WbReady = 0;
        @(posedge Clk);
        check("rst_status", 32'({ValidOut, DirtyOut}), 32'(0));
        check("rst_flags", 32'({Busy, Done, WbValid}), 32'(0));
        check("rst_wb", 32'({WbIndex, WbWay}), 32'(0));
        #2 Reset_n = 1'b1;
        @(posedge Clk);

        // Same-edge read returns the old value, next edge sees the write; dirty gated by valid.
        idle_edge(5, 1, 1, 1, 1);
        idle_edge(5, 0, 0, 0, 0);
        idle_edge(3, 1, 0, 0, 1);
        idle_edge(3, 0, 0, 0, 0);

        for (int i = 0; i < 150; i++)
            idle_edge($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 1));

        for (int i = 0; i < 16; i++) idle_edge(i >> 1, 1, i & 1, 1, $urandom_range(0, 1));
        run_invalidate();
        read_sweep();

        for (int i = 0; i < 16; i++) idle_edge(i >> 1, 1, i & 1, 1, (i == 4 || i == 15) ? 1 : 0);
        run_flush(0, 3);
        read_sweep();

        for (int i = 0; i < 40; i++)
            idle_edge($urandom_range(0, 7), 1, $urandom_range(0, 1),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 1));
        run_flush(1, 1);
        read_sweep();

        // Reset while an offer is pending.
        idle_edge(4, 1, 0, 1, 1);
        idle_edge(6, 1, 1, 1, 1);
        drive_edge(0, 0, 0, 0, 0, 0, 1, 0);
        n = 0;
        while (!WbValid && n < 50) begin
            n++;
            drive_edge(0, 0, 0, 0, 0, 0, 0, 0);
        end
        check("mid_wb", 32'({WbValid, Busy}), 32'(3));
        #2 Reset_n = 1'b0;
        #1;
        check("mid_rst_flags", 32'({WbValid, Busy, Done}), 32'(0));
        check("mid_rst_status", 32'({ValidOut, DirtyOut}), 32'(0));
        #1 Reset_n = 1'b1;
        model_clear();
        read_sweep();
        run_flush(1, 0);
        idle_edge(7, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
